edge_pulse_meter: RTL and testbench

Measures high time and period of a synchronized input signal, using the single-cycle rising/falling edge pulses from the 2-FF sync edge detector directly upstream. Each completed rise-to-rise cycle produces a measurement held in an output register. The register is drained by a valid/ready handshake into the capture logic or a CSR read path. Overrun and timeout conditions are reported as sticky flags.

---
 rtl/edge_pulse_meter.sv | 128 ++++++++++++
 tb/tb_edge_pulse_meter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_pulse_meter.sv
// Measures high time and period of a synchronized input from its rise/fall edge pulses.
// Each rise-to-rise cycle yields one result, drained through a valid/ready register.
module edge_pulse_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             edge_pos,
  input  logic             edge_neg,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             ovr_flag,
  output logic             tmo_flag
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] high_lat_q;

  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;
  logic             complete;
  logic             accept;
  logic             load;
  logic             ovr_set;
  logic             tmo_set;

  always_comb begin
    cnt_sat  = (cnt_q == CntMax);
    // Saturating increment so a fall pulse seen at CntMax cannot wrap the counter
    cnt_inc  = cnt_sat ? CntMax : cnt_q + CntOne;
    complete = en && (state_q == StLow) && edge_pos;
    accept   = meas_valid && meas_ready;
    load     = complete && (!meas_valid || meas_ready);
    ovr_set  = complete && meas_valid && !meas_ready;
    tmo_set  = 1'b0;
    if (en && cnt_sat) begin
      unique case (state_q)
        StHigh:  tmo_set = !edge_pos && !edge_neg;
        StLow:   tmo_set = !edge_pos;
        default: tmo_set = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      high_lat_q  <= '0;
      meas_high   <= '0;
      meas_period <= '0;
      meas_valid  <= 1'b0;
      ovr_flag    <= 1'b0;
      tmo_flag    <= 1'b0;
    end else begin
      if (!en) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (edge_pos) begin
              state_q <= StHigh;
              cnt_q   <= CntOne;
            end
          end
          StHigh: begin
            // A rise while high means the fall was missed: restart the measurement
            if (edge_pos) begin
              cnt_q <= CntOne;
            end else if (edge_neg) begin
              high_lat_q <= cnt_q;
              cnt_q      <= cnt_inc;
              state_q    <= StLow;
            end else if (cnt_sat) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StLow: begin
            if (edge_pos) begin
              cnt_q   <= CntOne;
              state_q <= StHigh;
            end else if (cnt_sat) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end

      if (load) begin
        meas_high   <= high_lat_q;
        meas_period <= cnt_q;
        meas_valid  <= 1'b1;
      end else if (accept) begin
        meas_valid <= 1'b0;
      end

      // Set beats clear when both land in the same cycle
      ovr_flag <= ovr_set || (ovr_flag && !clr_flags);
      tmo_flag <= tmo_set || (tmo_flag && !clr_flags);
    end
  end

endmodule

// File: tb/tb_edge_pulse_meter.sv
// Scoreboard bench for edge_pulse_meter at CNT_W=8: expected results are queued when the
// completing rise is driven and compared on every accepted handshake.
module tb_edge_pulse_meter;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             edge_pos;
  logic             edge_neg;
  logic             clr_flags;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_period;
  logic             meas_valid;
  logic             meas_ready;
  logic             ovr_flag;
  logic             tmo_flag;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned accepts     = 0;
  logic [15:0] sb_q[$];  // {high, period}

  edge_pulse_meter #(
    .CNT_W(CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .edge_pos   (edge_pos),
    .edge_neg   (edge_neg),
    .clr_flags  (clr_flags),
    .meas_high  (meas_high),
    .meas_period(meas_period),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .ovr_flag   (ovr_flag),
    .tmo_flag   (tmo_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle with the given edge pulses; returns 1 time unit after the edge
  task automatic cyc(input logic p, input logic n);
    edge_pos = p;
    edge_neg = n;
    @(posedge clk);
    #1;
    edge_pos = 1'b0;
    edge_neg = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0);
  endtask

  // Rise now, fall 'hi' cycles later, return at the cycle of the next rise 'per' after
  task automatic rise_fall(input int hi, input int per);
    cyc(1'b1, 1'b0);
    idle(hi - 1);
    cyc(1'b0, 1'b1);
    idle(per - hi - 1);
  endtask

  task automatic push(input int hi, input int per);
    sb_q.push_back({hi[7:0], per[7:0]});
  endtask

  task automatic flush();
    en = 1'b0;
    cyc(1'b0, 1'b0);
    en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && meas_valid && meas_ready) begin
      accepts++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(meas_valid), 32'd0);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        check("sb_high", 32'(meas_high), 32'(e[15:8]));
        check("sb_period", 32'(meas_period), 32'(e[7:0]));
      end
    end
  end

  initial begin
    int unsigned acc0;
    rst        = 1'b1;
    en         = 1'b1;
    edge_pos   = 1'b0;
    edge_neg   = 1'b0;
    clr_flags  = 1'b0;
    meas_ready = 1'b1;
    idle(2);
    check("rst_high", 32'(meas_high), 0);
    check("rst_period", 32'(meas_period), 0);
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_ovr", 32'(ovr_flag), 0);
    check("rst_tmo", 32'(tmo_flag), 0);
    rst = 1'b0;
    idle(2);

    // Rise, fall 3 later, rise 10 after the first
    rise_fall(3, 10);
    push(3, 10);
    cyc(1'b1, 1'b0);
    check("t1_valid", 32'(meas_valid), 1);
    check("t1_high", 32'(meas_high), 3);
    check("t1_period", 32'(meas_period), 10);
    idle(1);
    check("t1_valid_drop", 32'(meas_valid), 0);
    flush();

    // Square wave, period 8, high 5, consumer always ready
    acc0 = accepts;
    rise_fall(5, 8);
    for (int r = 0; r < 4; r++) begin
      push(5, 8);
      rise_fall(5, 8);
    end
    check("t2_accepts", accepts - acc0, 4);
    check("t2_ovr", 32'(ovr_flag), 0);
    check("t2_tmo", 32'(tmo_flag), 0);
    flush();

    // Same wave with consumer stalled: second completion overruns
    meas_ready = 1'b0;
    rise_fall(5, 8);
    push(5, 8);
    rise_fall(5, 8);
    check("t3_valid_held", 32'(meas_valid), 1);
    check("t3_ovr_before", 32'(ovr_flag), 0);
    cyc(1'b1, 1'b0);
    check("t3_ovr", 32'(ovr_flag), 1);
    check("t3_valid", 32'(meas_valid), 1);
    check("t3_high", 32'(meas_high), 5);
    check("t3_period", 32'(meas_period), 8);
    meas_ready = 1'b1;
    cyc(1'b0, 1'b0);
    check("t3_valid_drop", 32'(meas_valid), 0);
    flush();
    clr_flags = 1'b1;
    cyc(1'b0, 1'b0);
    clr_flags = 1'b0;
    check("t3_ovr_clr", 32'(ovr_flag), 0);

    // Single rise then silence: timeout 255 cycles after the rise pulse
    cyc(1'b1, 1'b0);
    idle(254);
    check("t4_tmo_early", 32'(tmo_flag), 0);
    idle(1);
    check("t4_tmo", 32'(tmo_flag), 1);
    check("t4_valid", 32'(meas_valid), 0);
    // In IDLE a lone fall followed by two rises must still measure normally
    cyc(1'b0, 1'b1);
    clr_flags = 1'b1;
    cyc(1'b0, 1'b0);
    clr_flags = 1'b0;
    check("t4_tmo_clr", 32'(tmo_flag), 0);

    // Missed fall: rises 4 apart, fall 2 after second rise, rise 3 later
    cyc(1'b1, 1'b0);
    idle(3);
    cyc(1'b1, 1'b0);
    idle(1);
    cyc(1'b0, 1'b1);
    idle(2);
    push(2, 5);
    cyc(1'b1, 1'b0);
    check("t5_valid", 32'(meas_valid), 1);
    check("t5_high", 32'(meas_high), 2);
    check("t5_period", 32'(meas_period), 5);
    flush();

    // Reset while in LOW with a held result and an overrun pending
    meas_ready = 1'b0;
    rise_fall(3, 7);
    push(3, 7);
    rise_fall(3, 6);
    cyc(1'b1, 1'b0);
    idle(1);
    cyc(1'b0, 1'b1);
    check("t6_pre_valid", 32'(meas_valid), 1);
    check("t6_pre_ovr", 32'(ovr_flag), 1);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    sb_q.delete();
    check("t6_high", 32'(meas_high), 0);
    check("t6_period", 32'(meas_period), 0);
    check("t6_valid", 32'(meas_valid), 0);
    check("t6_ovr", 32'(ovr_flag), 0);
    check("t6_tmo", 32'(tmo_flag), 0);
    meas_ready = 1'b1;
    rise_fall(2, 6);
    push(2, 6);
    cyc(1'b1, 1'b0);
    check("t6_new_valid", 32'(meas_valid), 1);
    idle(2);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
